// File: rtl/fft_mag_arbiter.sv
// Two-channel frame-level arbiter feeding an |I|,|Q| magnitude estimator
// (max + min/4) through a 3-stage pipeline into a credit-guarded result FIFO.
module fft_mag_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic signed [15:0] s0_i,
  input  logic signed [15:0] s0_q,
  input  logic               s0_last,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic signed [15:0] s1_i,
  input  logic signed [15:0] s1_q,
  input  logic               s1_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [15:0]        m_data,
  output logic               m_chan,
  output logic               m_last
);
  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; a source holds its payload stable while valid=1 and ready=0.
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic          c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic          l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  logic [14:0]   ai_q, ai_d, aq_q, aq_d, mx_q, mx_d, mn_q, mn_d;
  logic [15:0]   sum_q, sum_d;
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [17:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [AW+1:0]      used;
  logic               credit, acc, in_chan, in_last, wr, rd;
  logic signed [15:0] in_i, in_q;

  // -32768 has no positive counterpart in 16 bits, so it clamps to 32767.
  function automatic logic [14:0] abs15(input logic signed [15:0] x);
    logic [15:0] n;
    n = 16'(-x);
    if (!x[15])               return x[14:0];
    else if (x == 16'sh8000)  return 15'h7fff;
    else                      return n[14:0];
  endfunction

  always_comb begin
    used     = {1'b0, cnt_q} + (AW+2)'(v1_q) + (AW+2)'(v2_q) + (AW+2)'(v3_q);
    credit   = used < (AW+2)'(FIFO_DEPTH);
    s0_ready = (state_q == LOCK0) && credit;
    s1_ready = (state_q == LOCK1) && credit;
    in_chan  = (state_q == LOCK1);
    acc      = in_chan ? (s1_valid && s1_ready) : (s0_valid && s0_ready);
    in_i     = in_chan ? s1_i : s0_i;
    in_q     = in_chan ? s1_q : s0_q;
    in_last  = in_chan ? s1_last : s0_last;

    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) state_d = rr_q ? LOCK1 : LOCK0;
        else if (s0_valid)        state_d = LOCK0;
        else if (s1_valid)        state_d = LOCK1;
      end
      LOCK0, LOCK1: begin
        if (acc && in_last) begin
          state_d = IDLE;
          rr_d    = ~in_chan;
        end
      end
      default: state_d = IDLE;
    endcase

    v1_d  = acc;
    c1_d  = in_chan;
    l1_d  = in_last;
    ai_d  = abs15(in_i);
    aq_d  = abs15(in_q);
    v2_d  = v1_q;
    c2_d  = c1_q;
    l2_d  = l1_q;
    mx_d  = (ai_q >= aq_q) ? ai_q : aq_q;
    mn_d  = (ai_q >= aq_q) ? aq_q : ai_q;
    v3_d  = v2_q;
    c3_d  = c2_q;
    l3_d  = l2_q;
    sum_d = {1'b0, mx_q} + {3'b000, mn_q[14:2]};

    // Credits guarantee room for every stage-3 result, so writes never check full.
    wr      = v3_q;
    m_valid = (cnt_q != '0);
    rd      = m_valid && m_ready;
    mem_d   = mem_q;
    if (wr) mem_d[wp_q] = {c3_q, l3_q, sum_q};
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    {m_chan, m_last, m_data} = m_valid ? mem_q[rp_q] : 18'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload registers only matter alongside their valid bits.
  always_ff @(posedge clk) begin
    c1_q  <= c1_d;
    l1_q  <= l1_d;
    ai_q  <= ai_d;
    aq_q  <= aq_d;
    c2_q  <= c2_d;
    l2_q  <= l2_d;
    mx_q  <= mx_d;
    mn_q  <= mn_d;
    c3_q  <= c3_d;
    l3_q  <= l3_d;
    sum_q <= sum_d;
    mem_q <= mem_d;
  end
endmodule
